cps_a_rom_slot_sched: RTL and testbench
=======================================

// Module: cps_a_rom_slot_sched
// PURPOSE
//  Time-slot scheduler for the A-board -> B-board tile ROM bus. From each HBLANK_N fall it runs a fixed 8-slot table
//  (sprite,scroll1,scroll2,scroll3,stars,scroll1,scroll2,scroll3) for ROUNDS rounds. It grants one layer fetcher per slot,
//  drives ROMA/ROM_REQ, handshakes ROM_ACK and routes the 64-bit ROM word back to the owning layer. Sits between layer fetchers and B-board.
// PARAMETERS
//  SLOT_CYCLES  4   clocks per slot (legal >=2); last cycle of a slot is the ACK deadline
//  ROUNDS       16  8-slot rounds per line (16 -> 16 sprite/stars, 32 scroll fetches per line)
// PORTS
//  CLK          in   1    system clock; single clock domain
//  RESET        in   1    synchronous, active-high reset
//  HBLANK_N     in   1    falling edge starts a line schedule
//  REQ_VALID    in   5    per-layer fetch pending [0]=sprite [1]=scroll1 [2]=scroll2 [3]=scroll3 [4]=stars
//  REQ_ADDR     in   100  per-layer low address, layer n at [20n+19:20n]
//  REQ_GNT      out  5    one-hot 1-cycle pulse: layer's REQ_ADDR accepted this cycle
//  ROMA         out  23   {type[2:0], addr[19:0]}; type = 0..4 per layer
//  ROM_REQ      out  1    ROM access request, held until ACK or deadline
//  ROM_ACK      in   1    ROM data valid; only sampled while ROM_REQ=1
//  ROM_DATA     in   64   tile ROM word (16 4bpp pixels)
//  RD_VALID     out  5    one-hot 1-cycle pulse: RD_DATA belongs to that layer
//  RD_DATA      out  64   registered ROM_DATA
//  BUSY         out  1    schedule running
//  LINE_DONE    out  1    1-cycle pulse after last slot of last round
//  ROM_TIMEOUT  out  1    1-cycle pulse: slot deadline passed without ACK
//  LINE_ABORT   out  1    1-cycle pulse: HBLANK_N fell while BUSY
// BEHAVIOUR
//  - Reset: every output 0 (ROMA=0, RD_DATA=0), state IDLE, counters 0, HBLANK_N edge register := 1.
//  - Edge detect: hb_q <= HBLANK_N; start = hb_q & ~HBLANK_N. Slot 0 cycle 0 is the cycle after start is seen.
//  - States: IDLE -(start)-> RUN -(last cycle, slot 7, round ROUNDS-1)-> IDLE + LINE_DONE. BUSY = (state==RUN).
//  - Counters: cyc 0..SLOT_CYCLES-1, slot 0..7, round 0..ROUNDS-1; slot/round advance when cyc wraps.
//  - Slot cycle 0: owner L from table; if REQ_VALID[L]: REQ_GNT[L]=1 that cycle (combinational from state),
//    ROMA and ROM_REQ registered -> visible cycle 1. If REQ_VALID[L]=0: slot idle, no ROM_REQ, no GNT.
//  - ACK: ROM_ACK=1 while ROM_REQ=1 -> next cycle ROM_REQ=0, RD_VALID[L]=1, RD_DATA=ROM_DATA captured. ACK with ROM_REQ=0 ignored.
//  - Deadline: ROM_REQ still 1 at slot last cycle with no ACK -> next cycle ROM_REQ=0, ROM_TIMEOUT=1, no RD_VALID.
//    ACK on the last cycle counts as success (RD_VALID, no timeout). ROM_REQ never spans a slot boundary.
//  - ROMA holds last issued value between requests; changes only at issue.
//  - start while RUN: restart at slot 0/round 0 next cycle, drop ROM_REQ, suppress pending RD_VALID, LINE_ABORT=1; no LINE_DONE.
//  - start in the same cycle as final-slot completion: LINE_DONE=1 and new schedule begins (no LINE_ABORT).
//  - RESET mid-line overrides everything: outputs 0 on next edge, no LINE_DONE/LINE_ABORT.
// CONFIGURATION
//  CPS_A_STARS_EN defined: slot 4 serves stars (layer 4, type 3'b100).
//  Not defined: slot 4 always idle; REQ_VALID[4] ignored; REQ_GNT[4], RD_VALID[4] tied 0; slot timing unchanged.
// STRUCTURE
//  - Package cps_a_pkg: layer index enum (SPR,SC1,SC2,SC3,STR), ROMA type codes, 8-entry slot table constant,
//    ADDR_W=20, ROMA_W=23, ROM_DATA_W=64.
//  - Sub-module cps_a_slot_counter: cyc/slot/round counters, start/restart, slot_first, slot_last, line_last strobes.
//  - Top: FSM, issue/ACK/deadline logic, address mux, data return register.
// TESTING
//  1 All REQ_VALID=1, ACK 2 cycles after ROM_REQ -> 128 GNT, 128 RD_VALID in table order, ROMA[22:20] = 0,1,2,3,4,1,2,3 repeating, LINE_DONE once at 8*16*4 cycles after start.
//  2 ACK never asserted -> ROM_REQ high cycles 1..3 of each slot, ROM_TIMEOUT each active slot, no RD_VALID.
//  3 ACK exactly on slot last cycle, ROM_DATA=64'hDEADBEEF_01234567 -> RD_VALID next cycle with that data, no timeout.
//  4 HBLANK_N falls at round 5 slot 2 with ROM_REQ up -> LINE_ABORT, ROM_REQ=0, no RD_VALID, next GNT is sprite.
//  5 Only REQ_VALID[2]=1 (scroll2 addr 20'hABCDE) -> GNT only in slots 2 and 6, ROMA=23'h2ABCDE; other slots silent.
//  6 CPS_A_STARS_EN undefined, REQ_VALID[4]=1 -> slot 4 idle every round; RESET mid-line -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cps_a_rom_slot_sched_pkg.sv
// Widths, layer/type codes and the fixed 8-slot ownership table for the A-board tile ROM scheduler.
package cps_a_pkg;

  localparam int ADDR_W     = 20;
  localparam int ROMA_W     = 23;
  localparam int ROM_DATA_W = 64;
  localparam int N_LAYERS   = 5;
  localparam int N_SLOTS    = 8;

  typedef enum logic [2:0] {
    SPR = 3'd0,
    SC1 = 3'd1,
    SC2 = 3'd2,
    SC3 = 3'd3,
    STR = 3'd4
  } layer_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  localparam logic [2:0] TYPE_SPR = 3'b000;
  localparam logic [2:0] TYPE_SC1 = 3'b001;
  localparam logic [2:0] TYPE_SC2 = 3'b010;
  localparam logic [2:0] TYPE_SC3 = 3'b011;
  localparam logic [2:0] TYPE_STR = 3'b100;

  typedef struct packed {
    logic [2:0]        typ;
    logic [ADDR_W-1:0] addr;
  } roma_t;

  // Slot 0 sits in the low 3 bits; scroll layers get two slots per round.
  localparam logic [3*N_SLOTS-1:0] SLOT_TABLE = {SC3, SC2, SC1, STR, SC3, SC2, SC1, SPR};

  function automatic layer_e slot_owner(input logic [2:0] slot);
    return layer_e'(SLOT_TABLE[3*slot +: 3]);
  endfunction

  function automatic logic [2:0] layer_type(input layer_e l);
    case (l)
      SPR:     return TYPE_SPR;
      SC1:     return TYPE_SC1;
      SC2:     return TYPE_SC2;
      SC3:     return TYPE_SC3;
      STR:     return TYPE_STR;
      default: return TYPE_SPR;
    endcase
  endfunction

endpackage

// File: rtl/cps_a_rom_slot_sched_if.sv
// Layer-fetcher / B-board ROM bus bundle; master = scheduler side, slave = fetchers plus ROM.
interface cps_a_rom_slot_sched_if;
  import cps_a_pkg::*;

  logic                         HBLANK_N;
  logic [N_LAYERS-1:0]          REQ_VALID;
  logic [N_LAYERS*ADDR_W-1:0]   REQ_ADDR;
  logic [N_LAYERS-1:0]          REQ_GNT;
  logic [ROMA_W-1:0]            ROMA;
  logic                         ROM_REQ;
  logic                         ROM_ACK;
  logic [ROM_DATA_W-1:0]        ROM_DATA;
  logic [N_LAYERS-1:0]          RD_VALID;
  logic [ROM_DATA_W-1:0]        RD_DATA;
  logic                         BUSY;
  logic                         LINE_DONE;
  logic                         ROM_TIMEOUT;
  logic                         LINE_ABORT;

  modport master (
    input  HBLANK_N, REQ_VALID, REQ_ADDR, ROM_ACK, ROM_DATA,
    output REQ_GNT, ROMA, ROM_REQ, RD_VALID, RD_DATA, BUSY, LINE_DONE, ROM_TIMEOUT, LINE_ABORT
  );

  modport slave (
    output HBLANK_N, REQ_VALID, REQ_ADDR, ROM_ACK, ROM_DATA,
    input  REQ_GNT, ROMA, ROM_REQ, RD_VALID, RD_DATA, BUSY, LINE_DONE, ROM_TIMEOUT, LINE_ABORT
  );

endinterface

// File: rtl/cps_a_rom_slot_sched_slot_counter.sv
// Cycle/slot/round position within a line schedule; start (or restart) zeroes all counters.
// Strobes are combinational from the counters and qualified by run.
module cps_a_slot_counter #(
  parameter int SLOT_CYCLES = 4,
  parameter int ROUNDS      = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       run,
  input  logic       start,
  output logic [2:0] slot,
  output logic       slot_first,
  output logic       slot_last,
  output logic       line_last
);

  localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  logic [CYC_W-1:0] cyc_q;
  logic [2:0]       slot_q;
  logic [RND_W-1:0] round_q;

  always_ff @(posedge CLK) begin
    if (RESET || start) begin
      cyc_q   <= '0;
      slot_q  <= '0;
      round_q <= '0;
    end else if (run) begin
      if (cyc_q == CYC_LAST) begin
        cyc_q  <= '0;
        slot_q <= slot_q + 3'd1;
        if (slot_q == 3'd7) begin
          round_q <= (round_q == RND_LAST) ? '0 : round_q + RND_W'(1);
        end
      end else begin
        cyc_q <= cyc_q + CYC_W'(1);
      end
    end
  end

  assign slot       = slot_q;
  assign slot_first = run & (cyc_q == '0);
  assign slot_last  = run & (cyc_q == CYC_LAST);
  assign line_last  = slot_last & (slot_q == 3'd7) & (round_q == RND_LAST);

endmodule

// File: rtl/cps_a_rom_slot_sched.sv
// Per-line slot scheduler for the tile ROM bus: grants at slot cycle 0, ROM_REQ from cycle 1 until ACK or slot end.
// RD_VALID/RD_DATA one cycle after ACK; no backpressure, unanswered slots time out. CPS_A_STARS_EN enables slot 4 (stars).
module cps_a_rom_slot_sched
  import cps_a_pkg::*;
#(
  parameter int SLOT_CYCLES = 4,
  parameter int ROUNDS      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  cps_a_rom_slot_sched_if.master bus
);

`ifdef CPS_A_STARS_EN
  localparam logic [N_LAYERS-1:0] LAYER_EN = 5'b11111;
`else
  localparam logic [N_LAYERS-1:0] LAYER_EN = 5'b01111;
`endif

  sched_state_e state_q, state_d;

  logic                  hb_q;
  logic                  start;
  logic                  run;
  logic                  abort;
  logic                  issue;
  logic [2:0]            slot;
  logic                  slot_first;
  logic                  slot_last;
  logic                  line_last;
  layer_e                owner;
  layer_e                req_owner_q;
  logic [N_LAYERS-1:0]   req_vld;
  logic [N_LAYERS-1:0]   gnt;
  roma_t                 roma_q;
  logic                  rom_req_q;
  logic [N_LAYERS-1:0]   rd_valid_q;
  logic [ROM_DATA_W-1:0] rd_data_q;
  logic                  line_done_q;
  logic                  timeout_q;
  logic                  abort_q;

  assign start   = hb_q & ~bus.HBLANK_N;
  assign run     = (state_q == RUN);
  assign owner   = slot_owner(slot);
  assign req_vld = bus.REQ_VALID & LAYER_EN;

  cps_a_slot_counter #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .ROUNDS      (ROUNDS)
  ) u_cnt (
    .CLK        (CLK),
    .RESET      (RESET),
    .run        (run),
    .start      (start),
    .slot       (slot),
    .slot_first (slot_first),
    .slot_last  (slot_last),
    .line_last  (line_last)
  );

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    issue   = 1'b0;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        // A fall landing on the final cycle is a clean hand-over, not an abort.
        if (start) begin
          state_d = RUN;
          abort   = ~line_last;
        end else if (line_last) begin
          state_d = IDLE;
        end
        if (slot_first && req_vld[owner] && !abort) begin
          issue = 1'b1;
          gnt   = N_LAYERS'(1) << owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hb_q        <= 1'b1;
      state_q     <= IDLE;
      rom_req_q   <= 1'b0;
      roma_q      <= '0;
      req_owner_q <= SPR;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      line_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      hb_q        <= bus.HBLANK_N;
      state_q     <= state_d;
      rd_valid_q  <= '0;
      timeout_q   <= 1'b0;
      line_done_q <= line_last;
      abort_q     <= abort;
      if (abort) begin
        rom_req_q <= 1'b0;
      end else begin
        // ACK wins over the deadline so an answer on the last cycle still counts.
        if (rom_req_q && bus.ROM_ACK) begin
          rom_req_q  <= 1'b0;
          rd_valid_q <= N_LAYERS'(1) << req_owner_q;
          rd_data_q  <= bus.ROM_DATA;
        end else if (rom_req_q && slot_last) begin
          rom_req_q <= 1'b0;
          timeout_q <= 1'b1;
        end
        if (issue) begin
          rom_req_q   <= 1'b1;
          roma_q.typ  <= layer_type(owner);
          roma_q.addr <= bus.REQ_ADDR[ADDR_W*int'(owner) +: ADDR_W];
          req_owner_q <= owner;
        end
      end
    end
  end

  assign bus.REQ_GNT     = gnt;
  assign bus.ROMA        = roma_q;
  assign bus.ROM_REQ     = rom_req_q;
  assign bus.RD_VALID    = rd_valid_q;
  assign bus.RD_DATA     = rd_data_q;
  assign bus.BUSY        = run;
  assign bus.LINE_DONE   = line_done_q;
  assign bus.ROM_TIMEOUT = timeout_q;
  assign bus.LINE_ABORT  = abort_q;

endmodule

// File: tb/tb_cps_a_rom_slot_sched.sv
// Bench for cps_a_rom_slot_sched: whole-line vector table, hand-written corner sequences, and random traffic vs a line-position model.
module tb_cps_a_rom_slot_sched;
  import cps_a_pkg::*;

  localparam int SC   = 4;
  localparam int RN   = 16;
  localparam int LINE = SC * 8 * RN;
`ifdef CPS_A_STARS_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam int ACT = 112 + 16 * S;
  localparam logic [99:0] ADDRS = {20'h4A5A5, 20'h3C3C3, 20'hABCDE, 20'h1F0F0, 20'h0E1E1};

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  cps_a_rom_slot_sched_if bus();

  cps_a_rom_slot_sched #(.SLOT_CYCLES(SC), .ROUNDS(RN)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  valid;
    int          d;       // ACK on the d-th cycle of ROM_REQ; 3 = never
    int          e_gnt;
    int          e_rd;
    int          e_to;
    int          e_reqc;
    logic [22:0] e_roma;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [101:0] outs(input bit mask_data);
    logic [63:0] dd;
    dd = (mask_data && bus.RD_VALID == '0) ? 64'h0 : bus.RD_DATA;
    return {bus.REQ_GNT, bus.ROMA, bus.ROM_REQ, bus.RD_VALID, dd,
            bus.BUSY, bus.LINE_DONE, bus.ROM_TIMEOUT, bus.LINE_ABORT};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic go_idle();
    bus.HBLANK_N  = 1'b1;
    bus.REQ_VALID = '0;
    bus.ROM_ACK   = 1'b0;
    for (int i = 0; i < LINE + 20 && bus.BUSY; i++) tick();
    tick();
    settle();
    check("idle", bus.BUSY, 0);
  endtask

  task automatic run_line(input logic [4:0] valid, input int d,
                          output int c_gnt, output int c_rd, output int c_to, output int c_reqc,
                          output int c_done, output int c_abort, output int done_at);
    int age;
    age = 0; c_gnt = 0; c_rd = 0; c_to = 0; c_reqc = 0; c_done = 0; c_abort = 0; done_at = -1;
    bus.REQ_VALID = valid;
    bus.REQ_ADDR  = ADDRS;
    for (int n = 0; n < LINE + 16; n++) begin
      tick();
      bus.HBLANK_N = (n != 0);
      if (bus.ROM_REQ) begin
        bus.ROM_ACK = (age == d);
        age++;
      end else begin
        bus.ROM_ACK = 1'b0;
        age = 0;
      end
      bus.ROM_DATA = {$urandom, $urandom};
      settle();
      c_gnt   += $countones(bus.REQ_GNT);
      c_rd    += $countones(bus.RD_VALID);
      c_to    += int'(bus.ROM_TIMEOUT);
      c_reqc  += int'(bus.ROM_REQ);
      c_done  += int'(bus.LINE_DONE);
      c_abort += int'(bus.LINE_ABORT);
      if (bus.LINE_DONE && done_at < 0) done_at = n;
    end
    bus.REQ_VALID = '0;
    bus.ROM_ACK   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r, t, q, dn, ab, da;
    RESET         = 1'b1;
    bus.HBLANK_N  = 1'b1;
    bus.REQ_VALID = '0;
    bus.REQ_ADDR  = ADDRS;
    bus.ROM_ACK   = 1'b0;
    bus.ROM_DATA  = '0;

    tbl[0] = '{5'h1F, 2, ACT,    ACT,    0,   3*ACT, 23'h33C3C3};
    tbl[1] = '{5'h1F, 3, ACT,    0,      ACT, 3*ACT, 23'h33C3C3};
    tbl[2] = '{5'h04, 1, 32,     32,     0,   64,    23'h2ABCDE};
    tbl[3] = '{5'h10, 0, 16*S,   16*S,   0,   16*S,  (S != 0) ? 23'h44A5A5 : 23'h2ABCDE};
    tbl[4] = '{5'h00, 0, 0,      0,      0,   0,     (S != 0) ? 23'h44A5A5 : 23'h2ABCDE};
    tbl[5] = '{5'h01, 3, 16,     0,      16,  48,    23'h00E1E1};
    tbl[6] = '{5'h0A, 0, 64,     64,     0,   64,    23'h33C3C3};

    repeat (3) tick();
    settle();
    check("reset_outs", outs(1'b0), 0);
    tick();
    RESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_line(tbl[i].valid, tbl[i].d, g, r, t, q, dn, ab, da);
      check($sformatf("v%0d_gnt", i), g, tbl[i].e_gnt);
      check($sformatf("v%0d_rdvalid", i), r, tbl[i].e_rd);
      check($sformatf("v%0d_timeout", i), t, tbl[i].e_to);
      check($sformatf("v%0d_romreq_cycles", i), q, tbl[i].e_reqc);
      check($sformatf("v%0d_done_cnt", i), dn, 1);
      check($sformatf("v%0d_done_at", i), da, LINE + 1);
      check($sformatf("v%0d_abort_cnt", i), ab, 0);
      check($sformatf("v%0d_roma", i), bus.ROMA, tbl[i].e_roma);
    end

    // ACK on the deadline cycle still returns data.
    bus.REQ_VALID = 5'h01;
    bus.ROM_DATA  = 64'hDEADBEEF_01234567;
    for (int n = 0; n < 8; n++) begin
      tick();
      bus.HBLANK_N = (n != 0);
      bus.ROM_ACK  = (n == 4);
      settle();
      if (n == 4) check("lastack_req_up", bus.ROM_REQ, 1);
      if (n == 5) begin
        check("lastack_rdvalid", bus.RD_VALID, 5'h01);
        check("lastack_data", bus.RD_DATA, 64'hDEADBEEF_01234567);
        check("lastack_timeout", bus.ROM_TIMEOUT, 0);
        check("lastack_req_drop", bus.ROM_REQ, 0);
      end
    end
    go_idle();

    // HBLANK_N falls at round 5 slot 2 cycle 2 with ROM_REQ up and an ACK in the same cycle.
    begin
      int n_ab;
      n_ab = 1 + (5 * 8 + 2) * SC + 2;
      bus.REQ_VALID = 5'h1F;
      for (int n = 0; n <= n_ab + 1; n++) begin
        tick();
        bus.HBLANK_N = !(n == 0 || n == n_ab);
        bus.ROM_ACK  = (n == n_ab);
        settle();
        if (n == n_ab) check("abort_req_up", bus.ROM_REQ, 1);
        if (n == n_ab + 1) begin
          check("abort_pulse", bus.LINE_ABORT, 1);
          check("abort_req_drop", bus.ROM_REQ, 0);
          check("abort_no_rdvalid", bus.RD_VALID, 0);
          check("abort_no_timeout", bus.ROM_TIMEOUT, 0);
          check("abort_no_done", bus.LINE_DONE, 0);
          check("abort_next_gnt", bus.REQ_GNT, 5'h01);
        end
      end
      go_idle();
    end

    // RESET in the middle of a line.
    begin
      int cg, cd, ca;
      cg = 0; cd = 0; ca = 0;
      bus.REQ_VALID = 5'h1F;
      for (int n = 0; n < 102; n++) begin
        tick();
        bus.HBLANK_N = (n != 0);
        RESET        = (n == 100);
        bus.ROM_ACK  = bus.ROM_REQ;
        settle();
        if (n == 101) check("rst_mid_outs", outs(1'b0), 0);
      end
      for (int n = 0; n < LINE; n++) begin
        tick();
        bus.ROM_ACK = bus.ROM_REQ;
        settle();
        cg += $countones(bus.REQ_GNT);
        cd += int'(bus.LINE_DONE);
        ca += int'(bus.LINE_ABORT);
      end
      check("rst_mid_no_gnt", cg, 0);
      check("rst_mid_no_done", cd, 0);
      check("rst_mid_no_abort", ca, 0);
      bus.REQ_VALID = '0;
    end

    // Random traffic against a model that tracks only the cycle offset k within the line.
    begin
      int          own_tbl[8];
      logic [4:0]  en_mask;
      bit          m_run, m_hbq, hb, start, last, abrt;
      int          m_k, m_lay, own, ph;
      logic        e_req, n_req;
      logic [22:0] e_roma;
      logic [4:0]  e_rdv, e_gnt, valid;
      logic [63:0] e_rdd, data;
      logic [127:0] araw;
      logic [99:0] addr;
      bit          e_done, e_to, e_ab, ack;

      own_tbl = '{0, 1, 2, 3, 4, 1, 2, 3};
      en_mask = (S != 0) ? 5'h1F : 5'h0F;
      tick();
      RESET = 1'b1;
      bus.HBLANK_N = 1'b1;
      tick();
      RESET = 1'b0;
      m_run = 0; m_hbq = 1; m_k = 0; m_lay = 0;
      e_req = 0; e_roma = '0; e_rdv = '0; e_rdd = '0; e_done = 0; e_to = 0; e_ab = 0;

      for (int c = 0; c < 5000; c++) begin
        if (c != 0) tick();
        ph = m_k % SC;
        hb = 1;
        if (!m_run && m_hbq && $urandom_range(7) == 0) hb = 0;
        else if (m_run && m_hbq && ph != 0 && ph != SC - 1 && $urandom_range(999) == 0) hb = 0;
        else if (m_run && m_hbq && m_k == LINE - 1 && $urandom_range(1) == 0) hb = 0;
        valid = 5'($urandom);
        araw  = {$urandom, $urandom, $urandom, $urandom};
        addr  = araw[99:0];
        ack   = ($urandom_range(2) == 0);
        data  = {$urandom, $urandom};
        bus.HBLANK_N  = hb;
        bus.REQ_VALID = valid;
        bus.REQ_ADDR  = addr;
        bus.ROM_ACK   = ack;
        bus.ROM_DATA  = data;

        own   = own_tbl[(m_k / SC) % 8];
        e_gnt = (m_run && ph == 0 && (valid[own] & en_mask[own])) ? (5'd1 << own) : 5'd0;
        settle();
        check("rand_cycle", outs(1'b1),
              {e_gnt, e_roma, e_req, e_rdv, (e_rdv != 0) ? e_rdd : 64'h0, m_run, e_done, e_to, e_ab});

        start  = m_hbq && !hb;
        last   = m_run && (m_k == LINE - 1);
        abrt   = m_run && start && !last;
        e_done = last;
        e_ab   = abrt;
        e_to   = 0;
        n_req  = e_req;
        if (e_rdv != 0) e_rdv = '0;
        if (abrt) begin
          n_req = 0;
        end else begin
          if (e_req && ack) begin
            n_req = 0;
            e_rdv = 5'd1 << m_lay;
            e_rdd = data;
          end else if (e_req && ph == SC - 1) begin
            n_req = 0;
            e_to  = 1;
          end
          if (e_gnt != 0) begin
            n_req  = 1;
            e_roma = {3'(own), addr[20*own +: 20]};
            m_lay  = own;
          end
        end
        e_req = n_req;
        if (start) begin
          m_run = 1;
          m_k   = 0;
        end else if (last) begin
          m_run = 0;
          m_k   = 0;
        end else if (m_run) begin
          m_k++;
        end
        m_hbq = hb;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
